// File: rtl/char_renderer_if.sv
// Char RAM port B and char ROM read bus shared by the renderer and the memories.
// Both memories return registered data one clk_sys after the address.
interface char_renderer_if;
  logic [12:0] chram_addr;
  logic [7:0]  chram_data;
  logic [10:0] chrom_addr;
  logic [7:0]  chrom_data;

  modport master (
    output chram_addr,
    output chrom_addr,
    input  chram_data,
    input  chrom_data
  );

  modport slave (
    input  chram_addr,
    input  chrom_addr,
    output chram_data,
    output chrom_data
  );
endinterface

// File: rtl/char_renderer.sv
// 40x30 text-mode reader: fetches code, attribute and glyph row per 8-pixel cell,
// then serialises the glyph into 24-bit RGB using the attribute colours.
module char_renderer #(
  parameter logic [8:0] V_END = 9'd261
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   pix_ce,
  input  logic [8:0]             hcnt,
  input  logic [8:0]             vcnt,
  input  logic                   hblank,
  input  logic                   vblank,
  char_renderer_if.master        mem,
  output logic [23:0]            rgb
);

  typedef enum logic [2:0] {IDLE, C1, C2, A1, A2} fetch_state_t;

  fetch_state_t state, state_nxt;

  logic        cell_start;
  logic        trigger;
  logic [5:0]  tgt_col;
  logic [8:0]  tgt_line;
  logic [5:0]  tgt_row;
  logic        tgt_valid;
  logic [2:0]  glyph_line;
  logic        fetch_valid;
  logic [7:0]  next_glyph;
  logic [5:0]  next_attr;
  logic        next_valid;
  logic [6:0]  shifter;
  logic [5:0]  attr;
  logic        valid;
  logic [7:0]  cur_glyph;
  logic [5:0]  cur_attr;
  logic        cur_valid;
  logic [2:0]  cur_colour;
  logic [23:0] pix_rgb;

  assign cell_start = (hcnt[2:0] == 3'd0);
  assign trigger    = pix_ce && cell_start;

  // During blanking the fetch targets column 0 of the following line, so the
  // first visible cell is already waiting when hcnt wraps.
  always_comb begin
    tgt_col  = hcnt[8:3] + 6'd1;
    tgt_line = vcnt;
    if (hblank) begin
      tgt_col  = 6'd0;
      tgt_line = (vcnt == V_END) ? 9'd0 : vcnt + 9'd1;
    end
  end

  assign tgt_row   = tgt_line[8:3];
  assign tgt_valid = (tgt_col < 6'd40) && (tgt_row < 6'd30);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = C1;
      C1:      state_nxt = C2;
      C2:      state_nxt = A1;
      A1:      state_nxt = A2;
      A2:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mem.chram_addr <= '0;
      mem.chrom_addr <= '0;
      glyph_line     <= '0;
      fetch_valid    <= 1'b0;
      next_glyph     <= '0;
      next_attr      <= '0;
      next_valid     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (trigger) begin
            mem.chram_addr <= {2'b00, tgt_row[4:0], tgt_col};
            glyph_line     <= tgt_line[2:0];
            fetch_valid    <= tgt_valid;
          end
        end
        // The code byte is on chram_data now; attribute lives 0x800 higher.
        C2: begin
          mem.chram_addr <= {2'b01, mem.chram_addr[10:0]};
          mem.chrom_addr <= {mem.chram_data, glyph_line};
        end
        A2: begin
          next_glyph <= mem.chrom_data;
          next_attr  <= mem.chram_data[5:0];
          next_valid <= fetch_valid;
        end
        default: ;
      endcase
    end
  end

  // The pixel shown is the fresh cell on a cell boundary, otherwise the next
  // glyph bit; the shifter keeps only the bits still to be shown.
  always_comb begin
    cur_glyph = {shifter, 1'b0};
    cur_attr  = attr;
    cur_valid = valid;
    if (cell_start) begin
      cur_glyph = next_glyph;
      cur_attr  = next_attr;
      cur_valid = next_valid;
    end
    cur_colour = cur_glyph[7] ? cur_attr[2:0] : cur_attr[5:3];
    pix_rgb    = {{8{cur_colour[2]}}, {8{cur_colour[1]}}, {8{cur_colour[0]}}};
    if (hblank || vblank || !cur_valid) pix_rgb = '0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shifter <= '0;
      attr    <= '0;
      valid   <= 1'b0;
      rgb     <= '0;
    end else if (pix_ce) begin
      shifter <= cur_glyph[6:0];
      attr    <= cur_attr;
      valid   <= cur_valid;
      rgb     <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_char_renderer.sv
// Self-checking bench for char_renderer: drives video timing with random pixel
// gaps over random char RAM/ROM contents and compares rgb with a cell-level model.
module tb_char_renderer;

  localparam logic [8:0] V_END   = 9'd261;
  localparam int         H_TOTAL = 400;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        pix_ce;
  logic [8:0]  hcnt;
  logic [8:0]  vcnt;
  logic        hblank;
  logic        vblank;
  logic [23:0] rgb;

  char_renderer_if mem_if ();

  char_renderer #(.V_END(V_END)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .pix_ce  (pix_ce),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .hblank  (hblank),
    .vblank  (vblank),
    .mem     (mem_if),
    .rgb     (rgb)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] chram [0:8191];
  logic [7:0] chrom [0:2047];

  // Registered memories, one cycle of read latency.
  always @(posedge clk_sys) begin
    mem_if.chram_data <= chram[mem_if.chram_addr];
    mem_if.chrom_data <= chrom[mem_if.chrom_addr];
  end

  typedef struct packed {
    logic [7:0] glyph;
    logic [7:0] attr;
    logic       valid;
  } cell_t;

  cell_t m_cur;
  cell_t m_nxt;
  int    m_pos;
  int    tests;
  int    fails;

  logic [23:0] line_got [0:H_TOTAL-1];
  logic [23:0] line_exp [0:H_TOTAL-1];

  function automatic cell_t fetch_cell(input int col, input int line);
    cell_t c;
    int row, base, code;
    row     = line / 8;
    base    = (row % 32) * 64 + col;
    code    = int'(chram[base]);
    c.valid = (col < 40) && (row < 30);
    c.attr  = chram[2048 + base];
    c.glyph = chrom[code * 8 + line % 8];
    return c;
  endfunction

  task automatic model_reset();
    m_cur = '0;
    m_nxt = '0;
    m_pos = 0;
  endtask

  // Each cell boundary shows what the previous boundary fetched, then fetches anew.
  task automatic model_pixel(input int h, input int v, input bit hb, input bit vb,
                             output logic [23:0] exp);
    int col, line;
    logic [2:0] c;
    if (h % 8 == 0) begin
      m_cur = m_nxt;
      m_pos = 0;
      if (hb) begin
        col  = 0;
        line = (v == int'(V_END)) ? 0 : v + 1;
      end else begin
        col  = (h / 8 + 1) % 64;
        line = v;
      end
      m_nxt = fetch_cell(col, line);
    end else begin
      m_pos = m_pos + 1;
    end
    c   = m_cur.glyph[7 - m_pos] ? m_cur.attr[2:0] : m_cur.attr[5:3];
    exp = 24'h0;
    if (c[2]) exp = exp + 24'hFF0000;
    if (c[1]) exp = exp + 24'h00FF00;
    if (c[0]) exp = exp + 24'h0000FF;
    if (hb || vb || !m_cur.valid) exp = 24'h0;
  endtask

  task automatic drive_pixel(input int h, input int v, input bit hb, input bit vb,
                             output logic [23:0] got, output logic [23:0] exp);
    repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    @(negedge clk_sys);
    pix_ce = 1'b1;
    hcnt   = 9'(h);
    vcnt   = 9'(v);
    hblank = hb;
    vblank = vb;
    @(posedge clk_sys);
    #1;
    pix_ce = 1'b0;
    got    = rgb;
    model_pixel(h, v, hb, vb, exp);
  endtask

  // mode 0 normal, 1 forced vblank, 2 active extended over column 40,
  // 3 hblank forced over pixels 64..127.
  task automatic run_line(input int line, input int mode);
    int prev;
    bit hb, vb;
    logic [23:0] g, e;
    prev = (line == 0) ? int'(V_END) : line - 1;
    for (int h = 384; h < H_TOTAL; h++) drive_pixel(h, prev, 1'b1, prev >= 240, g, e);
    vb = (line >= 240) || (mode == 1);
    for (int h = 0; h < H_TOTAL; h++) begin
      hb = (mode == 2) ? (h >= 328) : (h >= 320);
      if (mode == 3 && h >= 64 && h < 128) hb = 1'b1;
      drive_pixel(h, line, hb, vb, g, e);
      line_got[h] = g;
      line_exp[h] = e;
    end
  endtask

  task automatic setup_memory();
    for (int i = 0; i < 8192; i++) chram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) chrom[i] = 8'($urandom);
    chram[12'h000] = 8'h41;  chram[12'h800] = 8'h07;  chrom[11'h208] = 8'h81;
    chram[12'h085] = 8'h22;  chram[12'h885] = 8'h0C;  chrom[11'h110] = 8'hF0;
    chram[12'h767] = 8'h12;
    chram[12'h040] = 8'h55;  chram[12'h840] = 8'h3A;  chrom[11'h2A8] = 8'h80;
    chram[12'h841] = 8'h3F;
    for (int c = 0; c < 42; c++) begin
      chram[3 * 64 + c]        = 8'h7F;
      chram[2048 + 3 * 64 + c] = 8'h07;
    end
    chrom[11'h3F8] = 8'hFF;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pix_ce  = 1'b0;
    hcnt    = '0;
    vcnt    = '0;
    hblank  = 1'b1;
    vblank  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_sys);
    tests++;
    if (rgb !== 24'h0) begin
      fails++;
      $display("[TB] FAIL reset_rgb got %h expected %h", rgb, 24'h0);
    end
    tests++;
    if (mem_if.chram_addr !== 13'h0) begin
      fails++;
      $display("[TB] FAIL reset_chram_addr got %h expected %h", mem_if.chram_addr, 13'h0);
    end
    tests++;
    if (mem_if.chrom_addr !== 11'h0) begin
      fails++;
      $display("[TB] FAIL reset_chrom_addr got %h expected %h", mem_if.chrom_addr, 11'h0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_glyph();
    run_line(0, 0);
    for (int h = 0; h < H_TOTAL; h++) begin
      tests++;
      if (line_got[h] !== line_exp[h]) begin
        fails++;
        $display("[TB] FAIL basic_line0 px=%0d got %h expected %h", h, line_got[h], line_exp[h]);
      end
    end
    for (int h = 0; h < 8; h++) begin
      tests++;
      if (line_got[h] !== ((h == 0 || h == 7) ? 24'hFFFFFF : 24'h000000)) begin
        fails++;
        $display("[TB] FAIL basic_glyph px=%0d got %h expected %h", h, line_got[h],
                 (h == 0 || h == 7) ? 24'hFFFFFF : 24'h000000);
      end
    end
  endtask

  task automatic test_background();
    run_line(16, 0);
    for (int h = 0; h < H_TOTAL; h++) begin
      tests++;
      if (line_got[h] !== line_exp[h]) begin
        fails++;
        $display("[TB] FAIL bg_line16 px=%0d got %h expected %h", h, line_got[h], line_exp[h]);
      end
    end
    for (int h = 40; h < 48; h++) begin
      tests++;
      if (line_got[h] !== ((h < 44) ? 24'hFF0000 : 24'h0000FF)) begin
        fails++;
        $display("[TB] FAIL bg_colour px=%0d got %h expected %h", h, line_got[h],
                 (h < 44) ? 24'hFF0000 : 24'h0000FF);
      end
    end
  endtask

  task automatic test_address_map();
    logic [23:0] g, e;
    bit found;
    drive_pixel(304, 237, 1'b0, 1'b0, g, e);
    tests++;
    if (mem_if.chram_addr !== 13'h0767) begin
      fails++;
      $display("[TB] FAIL addr_code got %h expected %h", mem_if.chram_addr, 13'h0767);
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk_sys);
      #1;
      if (mem_if.chram_addr === 13'h0F67) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL addr_attr got %h expected %h", mem_if.chram_addr, 13'h0F67);
    end
    tests++;
    if (mem_if.chrom_addr !== 11'h095) begin
      fails++;
      $display("[TB] FAIL addr_glyph got %h expected %h", mem_if.chrom_addr, 11'h095);
    end
    repeat (6) @(posedge clk_sys);
  endtask

  task automatic test_prefetch_wrap();
    run_line(8, 0);
    for (int h = 0; h < H_TOTAL; h++) begin
      tests++;
      if (line_got[h] !== line_exp[h]) begin
        fails++;
        $display("[TB] FAIL prefetch_line8 px=%0d got %h expected %h", h, line_got[h], line_exp[h]);
      end
    end
    tests++;
    if (line_got[0] !== 24'h00FF00) begin
      fails++;
      $display("[TB] FAIL prefetch_px0 got %h expected %h", line_got[0], 24'h00FF00);
    end
    tests++;
    if (line_got[1] !== 24'hFFFFFF) begin
      fails++;
      $display("[TB] FAIL prefetch_px1 got %h expected %h", line_got[1], 24'hFFFFFF);
    end
  endtask

  task automatic test_blanking();
    for (int mode = 1; mode <= 3; mode++) begin
      run_line(24, mode);
      for (int h = 0; h < H_TOTAL; h++) begin
        tests++;
        if (line_got[h] !== line_exp[h]) begin
          fails++;
          $display("[TB] FAIL blank_mode%0d px=%0d got %h expected %h", mode, h,
                   line_got[h], line_exp[h]);
        end
      end
      tests++;
      if (line_got[(mode == 2) ? 320 : 100] !== 24'h0) begin
        fails++;
        $display("[TB] FAIL blank_zero mode%0d got %h expected %h", mode,
                 line_got[(mode == 2) ? 320 : 100], 24'h0);
      end
    end
    tests++;
    if (line_got[200] !== 24'hFFFFFF) begin
      fails++;
      $display("[TB] FAIL blank_visible got %h expected %h", line_got[200], 24'hFFFFFF);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [23:0] g, e;
    for (int h = 384; h < H_TOTAL; h++) drive_pixel(h, 7, 1'b1, 1'b0, g, e);
    for (int h = 0; h <= 8; h++) begin
      drive_pixel(h, 8, 1'b0, 1'b0, g, e);
      tests++;
      if (g !== e) begin
        fails++;
        $display("[TB] FAIL midfetch_pre px=%0d got %h expected %h", h, g, e);
      end
    end
    tests++;
    if (g !== 24'hFFFFFF) begin
      fails++;
      $display("[TB] FAIL midfetch_white got %h expected %h", g, 24'hFFFFFF);
    end
    tests++;
    if (mem_if.chram_addr !== 13'h0042) begin
      fails++;
      $display("[TB] FAIL midfetch_addr got %h expected %h", mem_if.chram_addr, 13'h0042);
    end
    @(posedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (rgb !== 24'h0) begin
      fails++;
      $display("[TB] FAIL midfetch_rgb got %h expected %h", rgb, 24'h0);
    end
    tests++;
    if (mem_if.chram_addr !== 13'h0 || mem_if.chrom_addr !== 11'h0) begin
      fails++;
      $display("[TB] FAIL midfetch_addrs got %h/%h expected 0/0", mem_if.chram_addr,
               mem_if.chrom_addr);
    end
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    run_line(250, 0);
    for (int h = 0; h < H_TOTAL; h++) begin
      tests++;
      if (line_got[h] !== 24'h0) begin
        fails++;
        $display("[TB] FAIL vblank_line px=%0d got %h expected %h", h, line_got[h], 24'h0);
      end
    end
    run_line(8, 0);
    for (int h = 0; h < H_TOTAL; h++) begin
      tests++;
      if (line_got[h] !== line_exp[h]) begin
        fails++;
        $display("[TB] FAIL recover_line8 px=%0d got %h expected %h", h, line_got[h], line_exp[h]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    setup_memory();
    test_reset();
    test_basic_glyph();
    test_background();
    test_address_map();
    test_prefetch_wrap();
    test_blanking();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
